// File: rtl/ahb_lite_master.sv
// AHB-lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers.
// Two slots (address phase, data phase); one in-order response per accepted command.
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  // response stream
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  // AHB-lite bus
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  // address-phase slot
  logic        ap_nonseq_q, ap_nonseq_d;
  logic        ap_cancel_q, ap_cancel_d;
  logic [31:0] ap_addr_q, ap_addr_d;
  logic        ap_write_q, ap_write_d;
  logic [2:0]  ap_size_q, ap_size_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;

  // data-phase slot
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic        dp_cancel_q, dp_cancel_d;
  logic [2:0]  dp_size_q, dp_size_d;
  logic [1:0]  dp_lsb_q, dp_lsb_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;

  // response register
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        err_first;
  logic        cmd_accept;
  logic [2:0]  cmd_size_c;
  logic [31:0] cmd_addr_a;
  logic [31:0] rdata_ext;

  // First ERROR cycle: the slave is still holding HREADY low, nothing may be accepted.
  assign err_first  = dp_valid_q & HRESP & ~HREADY;
  assign cmd_ready  = HREADY & ~err_first;
  assign cmd_accept = cmd_valid & cmd_ready;

  assign cmd_size_c = (cmd_size > 3'd2) ? 3'd2 : cmd_size;

  always_comb begin
    cmd_addr_a = cmd_addr;
    case (cmd_size_c)
      3'd0:    cmd_addr_a = cmd_addr;
      3'd1:    cmd_addr_a = {cmd_addr[31:1], 1'b0};
      default: cmd_addr_a = {cmd_addr[31:2], 2'b00};
    endcase
  end

  always_comb begin
    rdata_ext = HRDATA;
    case (dp_size_q)
      3'd0:    rdata_ext = {24'h0, HRDATA[{dp_lsb_q, 3'b000} +: 8]};
      3'd1:    rdata_ext = dp_lsb_q[1] ? {16'h0, HRDATA[31:16]} : {16'h0, HRDATA[15:0]};
      default: rdata_ext = HRDATA;
    endcase
  end

  always_comb begin
    ap_nonseq_d = ap_nonseq_q;
    ap_cancel_d = ap_cancel_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_cancel_d = dp_cancel_q;
    dp_size_d   = dp_size_q;
    dp_lsb_d    = dp_lsb_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    if (HREADY) begin
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = dp_write_q;
        rsp_err_d   = dp_cancel_q | HRESP;
        // Errored or cancelled reads return zero rather than whatever the bus carried.
        rsp_rdata_d = (dp_write_q | dp_cancel_q | HRESP) ? 32'h0 : rdata_ext;
      end
      dp_valid_d  = ap_nonseq_q | ap_cancel_q;
      dp_write_d  = ap_write_q;
      dp_cancel_d = ap_cancel_q;
      dp_size_d   = ap_size_q;
      dp_lsb_d    = ap_addr_q[1:0];
      dp_wdata_d  = ap_wdata_q;
      ap_cancel_d = 1'b0;
      if (cmd_accept) begin
        ap_nonseq_d = 1'b1;
        ap_addr_d   = cmd_addr_a;
        ap_write_d  = cmd_write;
        ap_size_d   = cmd_size_c;
        ap_wdata_d  = cmd_wdata;
      end else begin
        ap_nonseq_d = 1'b0;
      end
    end else if (err_first && ap_nonseq_q) begin
      // Pull the queued transfer off the bus but keep it so it still gets a response.
      ap_nonseq_d = 1'b0;
      ap_cancel_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_nonseq_q <= 1'b0;
      ap_cancel_q <= 1'b0;
      ap_addr_q   <= 32'h0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 3'd0;
      ap_wdata_q  <= 32'h0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_cancel_q <= 1'b0;
      dp_size_q   <= 3'd0;
      dp_lsb_q    <= 2'd0;
      dp_wdata_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_nonseq_q <= ap_nonseq_d;
      ap_cancel_q <= ap_cancel_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_cancel_q <= dp_cancel_d;
      dp_size_q   <= dp_size_d;
      dp_lsb_q    <= dp_lsb_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    HWDATA = 32'h0;
    if (dp_valid_q && dp_write_q && !dp_cancel_q) begin
      case (dp_size_q)
        3'd0:    HWDATA = {4{dp_wdata_q[7:0]}};
        3'd1:    HWDATA = {2{dp_wdata_q[15:0]}};
        default: HWDATA = dp_wdata_q;
      endcase
    end
  end

  assign HADDR     = ap_addr_q;
  assign HTRANS    = ap_nonseq_q ? TransNonseq : TransIdle;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ap_nonseq_q | ap_cancel_q | dp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: behavioural AHB-lite slave (addr[31] -> ERROR, addr[30] -> 2 waits)
// plus bus and response scoreboards fed when commands are accepted.
module tb_ahb_lite_master;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] hwdata;
  } bus_t;

  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  logic [31:0] mem[256];
  logic [31:0] refmem[256];
  int          total = 0;
  int          bad = 0;

  // slave data-phase state
  bit          sd_valid, sd_write, sd_err, prev_stall;
  logic [31:0] sd_addr, sd_hwdata, prev_haddr;
  logic [2:0]  sd_size;
  logic [1:0]  prev_htrans;
  int          sd_cnt, sd_ws;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] sz);
    case (sz)
      3'd0:    return {24'h0, w[{lo, 3'b000} +: 8]};
      3'd1:    return lo[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Slave + response monitor: everything happens on the falling edge.
  initial begin
    logic hready_v, hresp_v;
    logic [7:0] idx;
    rsp_t e;
    bus_t b;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    sd_valid = 0; prev_stall = 0; sd_cnt = 0; sd_ws = 0;
    forever begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (!HRESETn) begin
        sd_valid = 0; prev_stall = 0;
        HREADY = 1'b1; HRESP = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
        if (prev_stall) begin
          check("hold_haddr", HADDR, prev_haddr);
          check("hold_htrans", 32'(HTRANS), 32'(prev_htrans));
        end
        hready_v = 1'b1; hresp_v = 1'b0;
        if (sd_valid) begin
          if (sd_err) begin
            hresp_v  = 1'b1;
            hready_v = (sd_cnt != 0);
          end else hready_v = (sd_cnt >= sd_ws);
        end
        HRDATA = $urandom();
        if (sd_valid && sd_err && sd_cnt == 1) check("err_htrans_idle", 32'(HTRANS), 32'h0);
        if (!(sd_valid && sd_write)) check("hwdata_idle", HWDATA, 32'h0);
        if (sd_valid && hready_v && !sd_err) begin
          idx = sd_addr[9:2];
          if (sd_write) begin
            check("hwdata", HWDATA, sd_hwdata);
            case (sd_size)
              3'd0: mem[idx][{sd_addr[1:0], 3'b000} +: 8] = HWDATA[{sd_addr[1:0], 3'b000} +: 8];
              3'd1: if (sd_addr[1]) mem[idx][31:16] = HWDATA[31:16];
                    else mem[idx][15:0] = HWDATA[15:0];
              default: mem[idx] = HWDATA;
            endcase
          end else HRDATA = mem[idx];
        end
        HREADY = hready_v; HRESP = hresp_v;
        prev_stall  = !hready_v && !(sd_valid && sd_err);
        prev_haddr  = HADDR;
        prev_htrans = HTRANS;
        if (hready_v) begin
          sd_valid = (HTRANS == 2'b10);
          sd_cnt   = 0;
          if (sd_valid) begin
            if (bus_q.size() == 0) begin
              check("bus_unexpected_nonseq", HADDR, 32'hFFFF_FFFF);
              sd_valid = 0;
            end else begin
              b = bus_q.pop_front();
              check("bus_haddr", HADDR, b.addr);
              check("bus_hwrite", 32'(HWRITE), 32'(b.write));
              check("bus_hsize", 32'(HSIZE), 32'(b.size));
              sd_addr = HADDR; sd_write = HWRITE; sd_size = HSIZE; sd_hwdata = b.hwdata;
              sd_err  = HADDR[31];
              sd_ws   = HADDR[30] ? 2 : 0;
            end
          end
        end else sd_cnt++;
        #1;
        if (!hready_v) check("stall_cmd_ready", 32'(cmd_ready), 32'h0);
      end
    end
  end

  // Drive one command; entered and left at posedge+1.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic cancelled);
    logic [2:0]  sz;
    logic [31:0] a, hw;
    logic [7:0]  i;
    logic [1:0]  lo;
    logic        err;
    rsp_t        r;
    bus_t        b;
    int          n;
    sz = (size > 3'd2) ? 3'd2 : size;
    a  = (sz == 3'd0) ? addr : (sz == 3'd1) ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
    i  = a[9:2];
    lo = a[1:0];
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    n = 0;
    do begin
      @(negedge HCLK); #1; n++;
    end while (cmd_ready !== 1'b1 && n < 50);
    if (cmd_ready !== 1'b1) begin
      check("accept_timeout", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b0;
      return;
    end
    err = cancelled | a[31];
    hw  = (sz == 3'd0) ? {4{wdata[7:0]}} : (sz == 3'd1) ? {2{wdata[15:0]}} : wdata;
    r.write = wr;
    r.err   = err;
    r.rdata = (wr || err) ? 32'h0 : exp_read(refmem[i], lo, sz);
    if (wr && !err) begin
      case (sz)
        3'd0:    refmem[i][{lo, 3'b000} +: 8] = wdata[7:0];
        3'd1:    if (lo[1]) refmem[i][31:16] = wdata[15:0]; else refmem[i][15:0] = wdata[15:0];
        default: refmem[i] = wdata;
      endcase
    end
    rsp_q.push_back(r);
    if (!cancelled) begin
      b.addr = a; b.write = wr; b.size = sz; b.hwdata = wr ? hw : 32'h0;
      bus_q.push_back(b);
    end
    @(posedge HCLK); #1;
    check("lat_htrans", 32'(HTRANS), 32'h2);
    check("lat_haddr", HADDR, a);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 60) begin
      @(posedge HCLK); n++;
    end
    check("drain_rsp_q", 32'(rsp_q.size()), 32'h0);
    check("drain_bus_q", 32'(bus_q.size()), 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    check("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]    = 32'h0101_0101 * k ^ 32'hA500_0000;
      refmem[k] = mem[k];
    end
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_wdata = 0;
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid0", 32'(rsp_valid), 32'h0);
    check("rst_rsp_write", 32'(rsp_write), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("hburst", 32'(HBURST), 32'h0);
    check("hprot", 32'(HPROT), 32'h3);
    check("hmastlock", 32'(HMASTLOCK), 32'h0);
    repeat (3) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // word write then read back
    send(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 1'b0);
    send(1'b0, 32'h0000_0010, 3'd2, 32'h0, 1'b0);
    drain();

    // byte write (replicated lanes), then word read shows the merged byte
    send(1'b1, 32'h0000_0013, 3'd0, 32'h0000_00A5, 1'b0);
    send(1'b0, 32'h0000_0010, 3'd2, 32'h0, 1'b0);
    drain();

    // half/byte extraction, clamped size, right-justified half write with junk upper bits
    send(1'b1, 32'h0000_0020, 3'd2, 32'h1234_5678, 1'b0);
    send(1'b0, 32'h0000_0022, 3'd1, 32'h0, 1'b0);
    send(1'b0, 32'h0000_0021, 3'd0, 32'h0, 1'b0);
    send(1'b0, 32'h0000_0023, 3'd7, 32'h0, 1'b0);
    send(1'b1, 32'h0000_0027, 3'd1, 32'hFFFF_CAFE, 1'b0);
    send(1'b0, 32'h0000_0024, 3'd2, 32'h0, 1'b0);
    drain();

    // three back-to-back reads, the second one wait-stated
    send(1'b0, 32'h0000_0010, 3'd2, 32'h0, 1'b0);
    send(1'b0, 32'h4000_0020, 3'd2, 32'h0, 1'b0);
    send(1'b0, 32'h0000_0013, 3'd0, 32'h0, 1'b0);
    drain();

    // ERROR on the first of two queued writes; the second is cancelled
    send(1'b1, 32'h8000_0040, 3'd2, 32'h1111_1111, 1'b0);
    send(1'b1, 32'h0000_0044, 3'd2, 32'h2222_2222, 1'b1);
    drain();
    send(1'b0, 32'h0000_0040, 3'd2, 32'h0, 1'b0);
    send(1'b0, 32'h0000_0044, 3'd2, 32'h0, 1'b0);
    drain();

    // reset during a wait-stated data phase
    send(1'b0, 32'h4000_0030, 3'd2, 32'h0, 1'b0);
    @(posedge HCLK);
    @(negedge HCLK); #2;
    check("pre_rst_busy", 32'(busy), 32'h1);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_htrans", 32'(HTRANS), 32'h0);
    check("mid_rst_haddr", HADDR, 32'h0);
    check("mid_rst_hwdata", HWDATA, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    send(1'b1, 32'h0000_0050, 3'd2, 32'hC0FF_EE00, 1'b0);
    send(1'b0, 32'h0000_0052, 3'd1, 32'h0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
